lmt_snapshot_ring: RTL

//  Parametrised successor to the single-table LMT mirror. Snoops CPU data-memory writes

---
 rtl/lmt_snapshot_ring.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lmt_snapshot_ring.sv
// Byte-accurate snoop mirror of the measured region plus an NUM_SLOTS-deep ring of
// snapshots, copied one word per clock and exposed read-only on the peripheral bus.
module lmt_snapshot_ring #(
  parameter logic [15:0] MR_BASE   = 16'h0230,
  parameter int          MR_WORDS  = 16,
  parameter int          NUM_SLOTS = 4,
  parameter logic [13:0] LMT_BASE  = 14'h0040,
  parameter logic [15:0] RESET_VAL = 16'h0005
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic [15:0] d_addr,
  input  logic [1:0]  w_en,
  input  logic [15:0] dmem_din,
  input  logic        upLMT,
  output logic        lmt_busy,
  output logic        lmt_done
);

  localparam int IDX_W = $clog2(MR_WORDS);
  localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam int TOTAL = NUM_SLOTS * MR_WORDS;
  localparam int ADR_W = $clog2(TOTAL);
  localparam int MR_LO = int'(MR_BASE);
  localparam int MR_HI = MR_LO + 2 * MR_WORDS;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] COPY = 1'b1;

  logic [15:0]      mirror [MR_WORDS];
  logic [15:0]      slots  [TOTAL];
  logic [0:0]       state;
  logic [IDX_W-1:0] k;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] valid_cnt;
  logic             overrun;
  logic             up_p1;

  logic             hit;
  logic [IDX_W-1:0] snoop_idx;
  logic             copying;
  logic             last;
  logic             rise;
  logic [ADR_W-1:0] copy_addr;
  logic [13:0]      off;
  logic             rd;
  logic             in_slots;
  logic             at_status;
  logic             status_clr;
  logic [15:0]      status_word;
  // unused: the peripheral bus never writes data into this block
  logic             per_din_unused;

  assign per_din_unused = ^per_din;

  assign hit       = (int'(d_addr) >= MR_LO) && (int'(d_addr) < MR_HI);
  assign snoop_idx = IDX_W'((int'(d_addr) - MR_LO) / 2);

  assign copying   = (state == COPY);
  assign last      = (int'(k) == MR_WORDS - 1);
  assign rise      = upLMT & ~up_p1;
  assign copy_addr = ADR_W'(int'(wr_ptr) * MR_WORDS + int'(k));

  assign lmt_busy  = copying;
  assign lmt_done  = copying & last;

  assign off         = per_addr - LMT_BASE;
  assign rd          = per_en && (per_we == 2'b00);
  assign in_slots    = int'(off) < TOTAL;
  assign at_status   = int'(off) == TOTAL;
  assign status_clr  = per_en && (per_we != 2'b00) && at_status;
  assign status_word = {overrun, lmt_busy, 2'b00, 4'(valid_cnt), 1'b0, 3'(wr_ptr), 4'b0000};

  always_comb begin
    per_dout = 16'h0000;
    if (rd && in_slots) begin
      per_dout = slots[off[ADR_W-1:0]];
    end else if (rd && at_status) begin
      per_dout = status_word;
    end
  end

  // Control: trigger edge detect, copy sequencing, ring pointer and sticky overrun
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state     <= IDLE;
      k         <= '0;
      wr_ptr    <= '0;
      valid_cnt <= '0;
      overrun   <= 1'b0;
      up_p1     <= 1'b0;
    end else begin
      up_p1 <= upLMT;
      if (rise && copying) begin
        overrun <= 1'b1;
      end else if (status_clr) begin
        overrun <= 1'b0;
      end
      if (state == IDLE) begin
        if (rise) begin
          state <= COPY;
          k     <= '0;
        end
      end else begin
        if (last) begin
          state <= IDLE;
          k     <= '0;
          if (int'(wr_ptr) == NUM_SLOTS - 1) begin
            wr_ptr <= '0;
          end else begin
            wr_ptr <= wr_ptr + PTR_W'(1);
          end
          if (int'(valid_cnt) < NUM_SLOTS) begin
            valid_cnt <= valid_cnt + CNT_W'(1);
          end
        end else begin
          k <= k + IDX_W'(1);
        end
      end
    end
  end

  // Mirror: byte-lane snoop of CPU writes into the measured region
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      for (int i = 0; i < MR_WORDS; i++) begin
        mirror[i] <= 16'h0000;
      end
    end else if (hit) begin
      if (w_en[1]) begin
        mirror[snoop_idx][15:8] <= dmem_din[15:8];
      end
      if (w_en[0]) begin
        mirror[snoop_idx][7:0] <= dmem_din[7:0];
      end
    end
  end

  // Snapshot ring: the copy reads the mirror as it stood before this edge
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      for (int i = 0; i < TOTAL; i++) begin
        slots[i] <= RESET_VAL;
      end
    end else if (copying) begin
      slots[copy_addr] <= mirror[k];
    end
  end

endmodule
